// File: rtl/mips_cpu_muldiv_seq_if.sv
// rtl/mips_cpu_muldiv_seq_if.sv - request/result bundle for the sequential HI/LO multiply-divide unit
interface mips_cpu_muldiv_seq_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, a, b,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mips_cpu_muldiv_seq.sv
// rtl/mips_cpu_muldiv_seq.sv - radix-2 sequential MULT/MULTU/DIV/DIVU with architectural HI/LO
module mips_cpu_muldiv_seq (
  input  logic                  clk,
  input  logic                  reset,
  mips_cpu_muldiv_seq_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CALC   = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  localparam logic [2:0] OP_MTHI = 3'b100;
  localparam logic [2:0] OP_MTLO = 3'b101;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] m_q, m_d;
  logic        is_mult_q, is_mult_d;
  logic        neg_q_q, neg_q_d;
  logic        neg_r_q, neg_r_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;

  logic        a_neg, b_neg;
  logic [31:0] mag_a, mag_b;
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [32:0] div_r;
  logic        div_ge;
  logic [31:0] div_rem;
  logic [63:0] div_next;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix, rem_fix;

  // Signed ops run on magnitudes; the sign is restored once in FINISH.
  assign a_neg = bus.op[1] & bus.a[31];
  assign b_neg = bus.op[1] & bus.b[31];
  assign mag_a = a_neg ? (32'd0 - bus.a) : bus.a;
  assign mag_b = b_neg ? (32'd0 - bus.b) : bus.b;

  assign mul_sum  = {1'b0, acc_q[63:32]} + {1'b0, (acc_q[0] ? m_q : 32'd0)};
  assign mul_next = {mul_sum, acc_q[31:1]};

  // Partial remainder is 33 bits wide; the kept remainder always fits in 32.
  assign div_r    = {acc_q[63:32], acc_q[31]};
  assign div_ge   = (div_r >= {1'b0, m_q});
  assign div_rem  = div_ge ? (div_r[31:0] - m_q) : div_r[31:0];
  assign div_next = {div_rem, acc_q[30:0], div_ge};

  assign prod_fix = neg_q_q ? (64'd0 - acc_q) : acc_q;
  assign quo_fix  = neg_q_q ? (32'd0 - acc_q[31:0]) : acc_q[31:0];
  assign rem_fix  = neg_r_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    m_d       = m_q;
    is_mult_d = is_mult_q;
    neg_q_d   = neg_q_q;
    neg_r_d   = neg_r_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (!bus.op[2]) begin
            is_mult_d = bus.op[0];
            cnt_d     = 5'd0;
            if (!bus.op[0] && (bus.b == 32'd0)) begin
              // Zero divisor: preload the final {hi, lo} so FINISH writes it unchanged.
              acc_d     = {bus.a, 32'hFFFF_FFFF};
              m_d       = 32'd0;
              neg_q_d   = 1'b0;
              neg_r_d   = 1'b0;
              state_d   = S_FINISH;
            end else if (bus.op[0]) begin
              acc_d     = {32'd0, mag_b};
              m_d       = mag_a;
              neg_q_d   = a_neg ^ b_neg;
              neg_r_d   = 1'b0;
              state_d   = S_CALC;
            end else begin
              acc_d     = {32'd0, mag_a};
              m_d       = mag_b;
              neg_q_d   = a_neg ^ b_neg;
              neg_r_d   = a_neg;
              state_d   = S_CALC;
            end
          end else if (bus.op == OP_MTHI) begin
            hi_d = bus.a;
          end else if (bus.op == OP_MTLO) begin
            lo_d = bus.a;
          end
        end
      end

      S_CALC: begin
        cnt_d = cnt_q + 5'd1;
        acc_d = is_mult_q ? mul_next : div_next;
        if (cnt_q == 5'd31) begin
          state_d = S_FINISH;
        end
      end

      S_FINISH: begin
        if (is_mult_q) begin
          hi_d = prod_fix[63:32];
          lo_d = prod_fix[31:0];
        end else begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= 5'd0;
      acc_q     <= 64'd0;
      m_q       <= 32'd0;
      is_mult_q <= 1'b0;
      neg_q_q   <= 1'b0;
      neg_r_q   <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      m_q       <= m_d;
      is_mult_q <= is_mult_d;
      neg_q_q   <= neg_q_d;
      neg_r_q   <= neg_r_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign bus.busy = (state_q != S_IDLE);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mips_cpu_muldiv_seq.sv
// tb/tb_mips_cpu_muldiv_seq.sv - directed-vector bench for mips_cpu_muldiv_seq
module tb_mips_cpu_muldiv_seq;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;
  int   lat;
  int   bcnt;
  logic seen;

  mips_cpu_muldiv_seq_if bus ();

  mips_cpu_muldiv_seq dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; start is seen at the next posedge (E0).
  task automatic launch(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv);
    bus.start = 1'b1;
    bus.op    = o;
    bus.a     = av;
    bus.b     = bv;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.op    = 3'b110;
    bus.a     = $urandom;
    bus.b     = $urandom;
  endtask

  // Returns at the negedge where done is high; lat counts cycles after start.
  task automatic wait_done(output int l, output int bc);
    l  = -1;
    bc = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (bus.busy) bc++;
      if (bus.done) begin
        l = k;
        break;
      end
    end
    if (l < 0) check_eq("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic run_op(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv,
                        output int l, output int bc);
    launch(o, av, bv);
    wait_done(l, bc);
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.op    = 3'b110;
    bus.a     = 32'd0;
    bus.b     = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_hi",   bus.hi,   32'd0);
    check_eq("rst_lo",   bus.lo,   32'd0);
    check_eq("rst_busy", bus.busy, 1'b0);
    check_eq("rst_done", bus.done, 1'b0);
    reset = 1'b0;
    @(negedge clk);

    run_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bcnt);
    check_eq("multu_lat",  lat,     34);
    check_eq("multu_busy", bcnt,    33);
    check_eq("multu_hi",   bus.hi,  32'hFFFF_FFFE);
    check_eq("multu_lo",   bus.lo,  32'h0000_0001);
    check_eq("done_cycle_busy", bus.busy, 1'b0);

    run_op(3'b011, 32'hFFFF_FFFD, 32'd7, lat, bcnt);
    check_eq("b2b_mult_lat", lat,    34);
    check_eq("mult_hi",      bus.hi, 32'hFFFF_FFFF);
    check_eq("mult_lo",      bus.lo, 32'hFFFF_FFEB);
    @(negedge clk);
    check_eq("done_pulse_width", bus.done, 1'b0);

    run_op(3'b010, 32'hFFFF_FFF9, 32'd2, lat, bcnt);
    check_eq("div_m7_2_lo", bus.lo, 32'hFFFF_FFFD);
    check_eq("div_m7_2_hi", bus.hi, 32'hFFFF_FFFF);

    run_op(3'b010, 32'd7, 32'hFFFF_FFFE, lat, bcnt);
    check_eq("div_7_m2_lo", bus.lo, 32'hFFFF_FFFD);
    check_eq("div_7_m2_hi", bus.hi, 32'd1);

    run_op(3'b000, 32'hFFFF_FFFF, 32'd16, lat, bcnt);
    check_eq("divu_lo", bus.lo, 32'h0FFF_FFFF);
    check_eq("divu_hi", bus.hi, 32'h0000_000F);

    run_op(3'b000, 32'd100, 32'd0, lat, bcnt);
    check_eq("dz_lat",  lat,    2);
    check_eq("dz_busy", bcnt,   1);
    check_eq("dz_hi",   bus.hi, 32'd100);
    check_eq("dz_lo",   bus.lo, 32'hFFFF_FFFF);

    run_op(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, lat, bcnt);
    check_eq("div_ovf_lo", bus.lo, 32'h8000_0000);
    check_eq("div_ovf_hi", bus.hi, 32'd0);

    bus.start = 1'b1;
    bus.op    = 3'b100;
    bus.a     = 32'h1234_5678;
    @(negedge clk);
    seen = bus.busy | bus.done;
    check_eq("mthi_hi", bus.hi, 32'h1234_5678);
    check_eq("mthi_lo", bus.lo, 32'h8000_0000);
    bus.op = 3'b101;
    bus.a  = 32'h9ABC_DEF0;
    @(negedge clk);
    seen = seen | bus.busy | bus.done;
    bus.start = 1'b0;
    bus.op    = 3'b110;
    check_eq("mtlo_hi", bus.hi, 32'h1234_5678);
    check_eq("mtlo_lo", bus.lo, 32'h9ABC_DEF0);
    @(negedge clk);
    seen = seen | bus.busy | bus.done;
    check_eq("mt_no_busy_done", seen, 1'b0);

    bus.start = 1'b1;
    bus.op    = 3'b111;
    bus.a     = 32'hFFFF_FFFF;
    @(negedge clk);
    bus.start = 1'b0;
    check_eq("nop_hi",   bus.hi,   32'h1234_5678);
    check_eq("nop_lo",   bus.lo,   32'h9ABC_DEF0);
    check_eq("nop_busy", bus.busy, 1'b0);

    launch(3'b000, 32'd50, 32'd7);
    repeat (10) @(negedge clk);
    check_eq("abort_busy_mid", bus.busy, 1'b1);
    check_eq("abort_hold_hi",  bus.hi,   32'h1234_5678);
    check_eq("abort_hold_lo",  bus.lo,   32'h9ABC_DEF0);
    reset = 1'b1;
    @(negedge clk);
    check_eq("abort_hi",   bus.hi,   32'd0);
    check_eq("abort_lo",   bus.lo,   32'd0);
    check_eq("abort_busy", bus.busy, 1'b0);
    check_eq("abort_done", bus.done, 1'b0);
    reset = 1'b0;
    @(negedge clk);

    run_op(3'b000, 32'd50, 32'd7, lat, bcnt);
    check_eq("post_rst_lat", lat,    34);
    check_eq("post_rst_lo",  bus.lo, 32'd7);
    check_eq("post_rst_hi",  bus.hi, 32'd1);

    launch(3'b001, 32'h0001_0001, 32'h0001_0001);
    repeat (5) @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 3'b101;
    bus.a     = 32'hDEAD_BEEF;
    @(negedge clk);
    bus.start = 1'b0;
    bus.op    = 3'b110;
    check_eq("mtlo_ign_lo_mid", bus.lo, 32'd7);
    wait_done(lat, bcnt);
    check_eq("mtlo_ign_hi", bus.hi, 32'h0000_0001);
    check_eq("mtlo_ign_lo", bus.lo, 32'h0002_0001);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
